// File: rtl/mesi_state_array.sv
// Registered MESI state store for SETS x WAYS lines: one line command per cycle, plus clear/print sweeps.
// Line results are registered on the accept edge, and respValid pulses on the following cycle.
module mesi_state_array #(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  localparam int SW  = $clog2(SETS),
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmdValid,
  output logic          cmdReady,
  input  logic [3:0]    command,
  input  logic [SW-1:0] setIndex,
  input  logic [WW-1:0] wayIndex,
  input  logic [1:0]    snoopResponse,
  output logic          respValid,
  output logic [1:0]    presentState,
  output logic [1:0]    resultState,
  output logic [2:0]    busOp,
  output logic [1:0]    putSnoop,
  output logic          cmdError,
  output logic          dumpValid,
  output logic [SW-1:0] dumpSet,
  output logic [WW-1:0] dumpWay,
  output logic [1:0]    dumpState
);

  localparam int LINES = SETS * WAYS;
  localparam int LW    = $clog2(LINES);

  localparam logic [1:0] ST_M = 2'b00;
  localparam logic [1:0] ST_E = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_I = 2'b11;

  localparam logic [2:0] BOP_NONE  = 3'd0;
  localparam logic [2:0] BOP_READ  = 3'd1;
  localparam logic [2:0] BOP_WRITE = 3'd2;
  localparam logic [2:0] BOP_INV   = 3'd3;
  localparam logic [2:0] BOP_RWIM  = 3'd4;

  localparam logic [1:0] SNP_NOHIT = 2'b00;
  localparam logic [1:0] SNP_HIT   = 2'b01;
  localparam logic [1:0] SNP_HITM  = 2'b10;

  localparam logic [3:0] CMD_L1_READ   = 4'd0;
  localparam logic [3:0] CMD_L1_WRITE  = 4'd1;
  localparam logic [3:0] CMD_L1_IREAD  = 4'd2;
  localparam logic [3:0] CMD_SNP_INV   = 4'd3;
  localparam logic [3:0] CMD_SNP_READ  = 4'd4;
  localparam logic [3:0] CMD_SNP_WRITE = 4'd5;
  localparam logic [3:0] CMD_SNP_RFO   = 4'd6;
  localparam logic [3:0] CMD_CLEAR     = 4'd8;
  localparam logic [3:0] CMD_PRINT     = 4'd9;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_CLEAR = 2'd1,
    FSM_PRINT = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [LW-1:0] scan_q, scan_d;
  logic [1:0]    mem_q [LINES];

  logic          resp_vld_q, resp_vld_d;
  logic [1:0]    present_q, present_d;
  logic [1:0]    result_q, result_d;
  logic [2:0]    busop_q, busop_d;
  logic [1:0]    putsnoop_q, putsnoop_d;
  logic          cmd_err_q, cmd_err_d;

  logic [LW-1:0] cmd_idx;
  logic [1:0]    cur_st;
  logic [1:0]    nxt_st;
  logic [2:0]    nxt_bop;
  logic [1:0]    nxt_snp;
  logic          nxt_err;
  logic          accept;
  logic          scan_last;
  logic          wr_en;
  logic [LW-1:0] wr_idx;
  logic [1:0]    wr_dat;

  // Linear line index is set-major, matching the sweep scan order.
  assign cmd_idx   = LW'(setIndex) * LW'(WAYS) + ((WAYS > 1) ? LW'(wayIndex) : '0);
  assign cur_st    = mem_q[cmd_idx];
  assign cmdReady  = (fsm_q == FSM_IDLE);
  assign accept    = cmdValid && cmdReady;
  assign scan_last = (scan_q == LW'(LINES - 1));

  always_comb begin
    nxt_st  = cur_st;
    nxt_bop = BOP_NONE;
    nxt_snp = SNP_NOHIT;
    nxt_err = 1'b0;
    case (command)
      CMD_L1_READ, CMD_L1_IREAD: begin
        if (cur_st == ST_I) begin
          nxt_st  = (snoopResponse == 2'b00) ? ST_E : ST_S;
          nxt_bop = BOP_READ;
        end
      end
      CMD_L1_WRITE: begin
        nxt_st = ST_M;
        if (cur_st == ST_S)      nxt_bop = BOP_INV;
        else if (cur_st == ST_I) nxt_bop = BOP_RWIM;
      end
      CMD_SNP_INV: begin
        if (cur_st == ST_S) begin
          nxt_st  = ST_I;
          nxt_snp = SNP_HIT;
        end
      end
      CMD_SNP_READ, CMD_SNP_RFO: begin
        if (cur_st != ST_I) begin
          nxt_st  = (command == CMD_SNP_READ) ? ST_S : ST_I;
          nxt_snp = (cur_st == ST_M) ? SNP_HITM : SNP_HIT;
          nxt_bop = (cur_st == ST_M) ? BOP_WRITE : BOP_NONE;
        end
      end
      CMD_SNP_WRITE, CMD_CLEAR, CMD_PRINT: ;
      default: nxt_err = 1'b1;
    endcase
  end

  always_comb begin
    fsm_d      = fsm_q;
    scan_d     = scan_q;
    wr_en      = 1'b0;
    wr_idx     = cmd_idx;
    wr_dat     = nxt_st;
    resp_vld_d = 1'b0;
    present_d  = present_q;
    result_d   = result_q;
    busop_d    = busop_q;
    putsnoop_d = putsnoop_q;
    cmd_err_d  = cmd_err_q;
    case (fsm_q)
      FSM_IDLE: begin
        if (accept) begin
          if (command == CMD_CLEAR) begin
            fsm_d  = FSM_CLEAR;
            scan_d = '0;
          end else if (command == CMD_PRINT) begin
            fsm_d  = FSM_PRINT;
            scan_d = '0;
          end else begin
            wr_en      = !nxt_err;
            resp_vld_d = 1'b1;
            present_d  = cur_st;
            result_d   = nxt_st;
            busop_d    = nxt_bop;
            putsnoop_d = nxt_snp;
            cmd_err_d  = nxt_err;
          end
        end
      end
      FSM_CLEAR, FSM_PRINT: begin
        if (fsm_q == FSM_CLEAR) begin
          wr_en  = 1'b1;
          wr_idx = scan_q;
          wr_dat = ST_I;
        end
        if (scan_last) begin
          fsm_d      = FSM_IDLE;
          scan_d     = '0;
          resp_vld_d = 1'b1;
          busop_d    = BOP_NONE;
          putsnoop_d = SNP_NOHIT;
          cmd_err_d  = 1'b0;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= FSM_IDLE;
      scan_q     <= '0;
      resp_vld_q <= 1'b0;
      present_q  <= ST_I;
      result_q   <= ST_I;
      busop_q    <= BOP_NONE;
      putsnoop_q <= SNP_NOHIT;
      cmd_err_q  <= 1'b0;
      for (int i = 0; i < LINES; i++) mem_q[i] <= ST_I;
    end else begin
      fsm_q      <= fsm_d;
      scan_q     <= scan_d;
      resp_vld_q <= resp_vld_d;
      present_q  <= present_d;
      result_q   <= result_d;
      busop_q    <= busop_d;
      putsnoop_q <= putsnoop_d;
      cmd_err_q  <= cmd_err_d;
      if (wr_en) mem_q[wr_idx] <= wr_dat;
    end
  end

  assign respValid    = resp_vld_q;
  assign presentState = present_q;
  assign resultState  = result_q;
  assign busOp        = busop_q;
  assign putSnoop     = putsnoop_q;
  assign cmdError     = cmd_err_q;

  // The dump port shows the line under the scan pointer while printing.
  assign dumpSet   = SW'(scan_q / LW'(WAYS));
  assign dumpWay   = WW'(scan_q % LW'(WAYS));
  assign dumpState = mem_q[scan_q];
  assign dumpValid = (fsm_q == FSM_PRINT) && (mem_q[scan_q] != ST_I);

endmodule

// File: tb/tb_mesi_state_array.sv
// Scoreboard bench for mesi_state_array: directed MESI scenarios, then randomized commands vs a table model.
module tb_mesi_state_array;
  localparam int SETS = 16;
  localparam int WAYS = 4;
  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmdValid;
  logic       cmdReady;
  logic [3:0] command;
  logic [3:0] setIndex;
  logic [1:0] wayIndex;
  logic [1:0] snoopResponse;
  logic       respValid;
  logic [1:0] presentState, resultState, putSnoop, dumpState;
  logic [2:0] busOp;
  logic       cmdError, dumpValid;
  logic [3:0] dumpSet;
  logic [1:0] dumpWay;

  always #5 clk = ~clk;

  mesi_state_array #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .command(command), .setIndex(setIndex), .wayIndex(wayIndex),
    .snoopResponse(snoopResponse), .respValid(respValid),
    .presentState(presentState), .resultState(resultState), .busOp(busOp),
    .putSnoop(putSnoop), .cmdError(cmdError), .dumpValid(dumpValid),
    .dumpSet(dumpSet), .dumpWay(dumpWay), .dumpState(dumpState)
  );

  typedef struct {
    bit         sweep;
    logic [1:0] pres;
    logic [1:0] res;
    logic [2:0] bop;
    logic [1:0] snp;
    logic       err;
  } exp_t;

  typedef struct {
    int         s;
    int         w;
    logic [1:0] st;
  } dump_t;

  exp_t       exp_q[$];
  dump_t      dump_q[$];
  logic [1:0] line_st [SETS][WAYS];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: the MESI rule table applied to one line.
  task automatic ref_line(input logic [3:0] c, input logic [1:0] sr, input logic [1:0] cur,
                          output exp_t e);
    e.sweep = 1'b0;
    e.pres  = cur;
    e.res   = cur;
    e.bop   = 3'd0;
    e.snp   = 2'd0;
    e.err   = !(c <= 4'd6);
    if ((c == 4'd0 || c == 4'd2) && cur == I) begin
      e.res = (sr == 2'd0) ? E : S;
      e.bop = 3'd1;
    end else if (c == 4'd1) begin
      e.res = M;
      e.bop = (cur == S) ? 3'd3 : (cur == I) ? 3'd4 : 3'd0;
    end else if (c == 4'd3 && cur == S) begin
      e.res = I;
      e.snp = 2'd1;
    end else if ((c == 4'd4 || c == 4'd6) && cur != I) begin
      e.res = (c == 4'd4) ? S : I;
      e.snp = (cur == M) ? 2'd2 : 2'd1;
      e.bop = (cur == M) ? 3'd2 : 3'd0;
    end
  endtask

  task automatic model_issue(input logic [3:0] c, input int s, input int w, input logic [1:0] sr);
    exp_t e;
    dump_t d;
    if (c == 4'd8 || c == 4'd9) begin
      for (int si = 0; si < SETS; si++)
        for (int wi = 0; wi < WAYS; wi++) begin
          if (c == 4'd8) line_st[si][wi] = I;
          else if (line_st[si][wi] != I) begin
            d.s = si; d.w = wi; d.st = line_st[si][wi];
            dump_q.push_back(d);
          end
        end
      e = '{sweep: 1'b1, pres: I, res: I, bop: 3'd0, snp: 2'd0, err: 1'b0};
    end else begin
      ref_line(c, sr, line_st[s][w], e);
      if (!e.err) line_st[s][w] = e.res;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [3:0] c, input int s, input int w, input logic [1:0] sr);
    int n;
    cmdValid = 1'b1; command = c; setIndex = 4'(s); wayIndex = 2'(w); snoopResponse = sr;
    n = 0;
    while (!cmdReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) begin
      chk("accept_timeout", 0, 1);
      cmdValid = 1'b0;
      return;
    end
    model_issue(c, s, w, sr);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (!cmdReady && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, SETS * WAYS);
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    dump_t d;
    if (rst_n) begin
      if (respValid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (!e.sweep) begin
            chk("presentState", presentState, e.pres);
            chk("resultState", resultState, e.res);
            chk("busOp", busOp, e.bop);
            chk("putSnoop", putSnoop, e.snp);
          end
          chk("cmdError", cmdError, e.err);
        end
      end
      if (dumpValid) begin
        if (dump_q.size() == 0) chk("dump_unexpected", 1, 0);
        else begin
          d = dump_q.pop_front();
          chk("dumpSet", dumpSet, d.s);
          chk("dumpWay", dumpWay, d.w);
          chk("dumpState", dumpState, d.st);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int r;
    int u;
    logic [3:0] c;
    rst_n = 1'b0; cmdValid = 1'b0; command = '0; setIndex = '0; wayIndex = '0; snoopResponse = '0;
    for (int si = 0; si < SETS; si++)
      for (int wi = 0; wi < WAYS; wi++) line_st[si][wi] = I;
    repeat (2) @(negedge clk);
    chk("rst_cmdReady", cmdReady, 1);
    chk("rst_respValid", respValid, 0);
    chk("rst_dumpValid", dumpValid, 0);
    chk("rst_cmdError", cmdError, 0);
    chk("rst_busOp", busOp, 0);
    chk("rst_putSnoop", putSnoop, 0);
    chk("rst_presentState", presentState, I);
    chk("rst_resultState", resultState, I);
    rst_n = 1'b1;
    @(negedge clk);

    // Line (3,1): I -> E, then E -> M, snoop paths, write from I and S.
    send(4'd5, 3, 1, 2'd0);
    send(4'd0, 3, 1, 2'd0);
    chk("resp_latency", respValid, 1);
    @(negedge clk);
    chk("resp_one_cycle", respValid, 0);
    send(4'd1, 3, 1, 2'd0);
    send(4'd4, 3, 1, 2'd0);
    send(4'd6, 3, 1, 2'd0);
    send(4'd0, 3, 1, 2'd0);
    send(4'd6, 3, 1, 2'd0);
    send(4'd1, 5, 2, 2'd0);
    send(4'd2, 6, 0, 2'd1);
    send(4'd1, 6, 0, 2'd0);
    send(4'd0, 7, 3, 2'd2);
    send(4'd3, 7, 3, 2'd0);
    send(4'd0, 8, 1, 2'd3);
    // Back-to-back on the same line: I->S then S->M with INVALIDATE.
    send(4'd0, 9, 2, 2'd1);
    send(4'd1, 9, 2, 2'd0);

    // Exactly 5 valid lines present, then print.
    send(4'd8, 0, 0, 2'd0);
    count_sweep("clear_ready_low");
    send(4'd1, 0, 0, 2'd0);
    send(4'd0, 3, 1, 2'd0);
    send(4'd0, 7, 2, 2'd1);
    send(4'd1, 12, 3, 2'd0);
    send(4'd2, 15, 3, 2'd0);
    send(4'd9, 0, 0, 2'd0);
    count_sweep("print_ready_low");
    @(negedge clk);
    chk("print_dumps_consumed", dump_q.size(), 0);

    // Reset during a clear sweep.
    send(4'd8, 0, 0, 2'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    dump_q.delete();
    for (int si = 0; si < SETS; si++)
      for (int wi = 0; wi < WAYS; wi++) line_st[si][wi] = I;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmdReady", cmdReady, 1);
    send(4'd9, 0, 0, 2'd0);
    count_sweep("print_after_reset");
    send(4'd1, 2, 2, 2'd0);
    send(4'b1011, 2, 2, 2'd0);
    send(4'd4, 2, 2, 2'd0);

    // Randomized traffic.
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 3) c = 4'd9;
      else if (r < 5) c = 4'd8;
      else if (r < 10) begin
        u = $urandom_range(0, 6);
        c = (u == 0) ? 4'd7 : 4'(9 + u);
      end else c = 4'($urandom_range(0, 6));
      send(c, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    u = 0;
    while (!cmdReady && u < 200) begin
      @(negedge clk);
      u++;
    end
    repeat (3) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("dump_queue_drained", dump_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
